// File: rtl/avmm_lvds_bridge_avs_arb.sv
// Round-robin arbiter that serialises N Avalon-MM burst slave channels onto one
// 32-bit request stream and returns read responses from a 32-bit response stream.
module avmm_lvds_bridge_avs_arb #(
  parameter int unsigned N_CH       = 2,
  parameter int unsigned ADDR_W     = 19,
  parameter int unsigned BURSTCNT_W = 11,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [N_CH*ADDR_W-1:0]     s_address_i,
  input  logic [N_CH*32-1:0]         s_writedata_i,
  input  logic [N_CH-1:0]            s_write_i,
  input  logic [N_CH-1:0]            s_read_i,
  input  logic [N_CH*BURSTCNT_W-1:0] s_burstcount_i,
  output logic [N_CH-1:0]            s_waitrequest_o,
  output logic [N_CH-1:0]            s_readdatavalid_o,
  output logic [31:0]                s_readdata_o,
  output logic [31:0]                req_data_o,
  output logic                       req_valid_o,
  input  logic                       req_ready_i,
  input  logic [31:0]                resp_data_i,
  input  logic                       resp_valid_i,
  output logic                       err_o
);

  localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, HDR, ADDR, WDATA, RWAIT} state_t;

  state_t                state_q, state_n;
  logic [CH_W-1:0]       grant_q, grant_n;
  logic [CH_W-1:0]       last_q, last_n;
  logic                  rnw_q, rnw_n;
  logic [ADDR_W-1:0]     addr_q, addr_n;
  logic [BURSTCNT_W-1:0] rem_q, rem_n;
  logic [TMR_W-1:0]      tmr_q, tmr_n;
  logic                  to_q, to_n;
  logic [31:0]           rdata_n;
  logic [N_CH-1:0]       rdv_n;
  logic                  err_n;

  logic                  found;
  logic [CH_W-1:0]       pick;
  logic [CH_W-1:0]       idx;
  logic                  last_beat;

  logic [ADDR_W-1:0]     addr_a  [N_CH];
  logic [31:0]           wdata_a [N_CH];
  logic [BURSTCNT_W-1:0] bc_a    [N_CH];

  // Per-channel views of the packed slave buses
  for (genvar k = 0; k < N_CH; k++) begin : g_unpack
    assign addr_a[k]  = s_address_i[k*ADDR_W +: ADDR_W];
    assign wdata_a[k] = s_writedata_i[k*32 +: 32];
    assign bc_a[k]    = s_burstcount_i[k*BURSTCNT_W +: BURSTCNT_W];
  end

  // State and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q           <= IDLE;
      grant_q           <= '0;
      last_q            <= CH_W'(N_CH - 1);
      rnw_q             <= 1'b0;
      addr_q            <= '0;
      rem_q             <= '0;
      tmr_q             <= '0;
      to_q              <= 1'b0;
      s_readdata_o      <= '0;
      s_readdatavalid_o <= '0;
      err_o             <= 1'b0;
    end else begin
      state_q           <= state_n;
      grant_q           <= grant_n;
      last_q            <= last_n;
      rnw_q             <= rnw_n;
      addr_q            <= addr_n;
      rem_q             <= rem_n;
      tmr_q             <= tmr_n;
      to_q              <= to_n;
      s_readdata_o      <= rdata_n;
      s_readdatavalid_o <= rdv_n;
      err_o             <= err_n;
    end
  end

  // Next-state, arbitration and stream-side outputs
  always_comb begin
    state_n         = state_q;
    grant_n         = grant_q;
    last_n          = last_q;
    rnw_n           = rnw_q;
    addr_n          = addr_q;
    rem_n           = rem_q;
    tmr_n           = tmr_q;
    to_n            = to_q;
    rdata_n         = s_readdata_o;
    rdv_n           = '0;
    err_n           = err_o;
    req_valid_o     = 1'b0;
    req_data_o      = '0;
    s_waitrequest_o = '1;
    found           = 1'b0;
    pick            = last_q;
    idx             = '0;
    last_beat       = (rem_q == BURSTCNT_W'(1));

    // Search starts just after the most recent grant
    for (int unsigned i = 1; i <= N_CH; i++) begin
      idx = CH_W'((32'(last_q) + i) % N_CH);
      if (!found && (s_read_i[idx] || s_write_i[idx])) begin
        found = 1'b1;
        pick  = idx;
      end
    end

    // Responses are only meaningful while a read is waiting
    if (resp_valid_i && (state_q != RWAIT || to_q)) begin
      err_n = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (found) begin
          grant_n = pick;
          last_n  = pick;
          rnw_n   = s_read_i[pick];
          addr_n  = addr_a[pick];
          rem_n   = (bc_a[pick] == '0) ? BURSTCNT_W'(1) : bc_a[pick];
          tmr_n   = '0;
          to_n    = 1'b0;
          state_n = HDR;
          if (s_read_i[pick] && s_write_i[pick]) begin
            err_n = 1'b1;
          end
        end
      end
      HDR: begin
        req_valid_o = 1'b1;
        req_data_o  = {rnw_q, 3'(grant_q), 12'b0, 16'(rem_q)};
        if (req_ready_i) begin
          state_n = ADDR;
        end
      end
      ADDR: begin
        req_valid_o = 1'b1;
        req_data_o  = 32'(addr_q);
        if (rnw_q) begin
          s_waitrequest_o[grant_q] = ~req_ready_i;
        end
        if (req_ready_i) begin
          state_n = rnw_q ? RWAIT : WDATA;
        end
      end
      WDATA: begin
        req_valid_o              = s_write_i[grant_q];
        req_data_o               = wdata_a[grant_q];
        s_waitrequest_o[grant_q] = ~req_ready_i;
        if (s_write_i[grant_q] && req_ready_i) begin
          rem_n = rem_q - BURSTCNT_W'(1);
          if (last_beat) begin
            state_n = IDLE;
          end
        end
      end
      RWAIT: begin
        if (to_q) begin
          // Timed out: flush remaining beats with a poison word
          rdata_n        = 32'hDEAD_BEEF;
          rdv_n[grant_q] = 1'b1;
          rem_n          = rem_q - BURSTCNT_W'(1);
          if (last_beat) begin
            state_n = IDLE;
          end
        end else if (resp_valid_i) begin
          rdata_n        = resp_data_i;
          rdv_n[grant_q] = 1'b1;
          rem_n          = rem_q - BURSTCNT_W'(1);
          tmr_n          = '0;
          if (last_beat) begin
            state_n = IDLE;
          end
        end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
          to_n  = 1'b1;
          err_n = 1'b1;
        end else begin
          tmr_n = tmr_q + TMR_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_avmm_lvds_bridge_avs_arb.sv
// Directed bench for avmm_lvds_bridge_avs_arb with a scoreboard of expected
// request words and read beats checked as the DUT produces them.
module tb_avmm_lvds_bridge_avs_arb;

  localparam int unsigned ADDR_W = 19;
  localparam int unsigned BW     = 11;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] addr_a  [2];
  logic [31:0]       wdata_a [2];
  logic [BW-1:0]     bc_a    [2];
  logic [1:0]        s_write_i, s_read_i;
  logic [1:0]        s_waitrequest_o, s_readdatavalid_o;
  logic [31:0]       s_readdata_o, req_data_o, resp_data_i;
  logic              req_valid_o, req_ready_i, resp_valid_i, err_o;

  int tests = 0;
  int fails = 0;

  logic [31:0] req_q [$];
  logic [32:0] rd_q  [$];

  avmm_lvds_bridge_avs_arb #(
    .N_CH(2), .ADDR_W(ADDR_W), .BURSTCNT_W(BW), .TIMEOUT(8)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .s_address_i      ({addr_a[1], addr_a[0]}),
    .s_writedata_i    ({wdata_a[1], wdata_a[0]}),
    .s_write_i        (s_write_i),
    .s_read_i         (s_read_i),
    .s_burstcount_i   ({bc_a[1], bc_a[0]}),
    .s_waitrequest_o  (s_waitrequest_o),
    .s_readdatavalid_o(s_readdatavalid_o),
    .s_readdata_o     (s_readdata_o),
    .req_data_o       (req_data_o),
    .req_valid_o      (req_valid_o),
    .req_ready_i      (req_ready_i),
    .resp_data_i      (resp_data_i),
    .resp_valid_i     (resp_valid_i),
    .err_o            (err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: compare every request transfer and read beat against the queues
  always @(negedge clk) begin
    if (!rst) begin
      if (req_valid_o && req_ready_i) begin
        tests++;
        assert (req_q.size() > 0) else begin
          fails++;
          $error("FAIL req_unexpected: got 0x%08h expected no word", req_data_o);
        end
        if (req_q.size() > 0) chk("req_word", req_data_o, req_q.pop_front());
      end
      if (s_readdatavalid_o != 2'b00) begin
        tests++;
        assert (rd_q.size() > 0) else begin
          fails++;
          $error("FAIL rdv_unexpected: got 0x%08h expected no beat", s_readdata_o);
        end
        if (rd_q.size() > 0) begin
          logic [32:0] e;
          e = rd_q.pop_front();
          chk("rdv_vec", 32'(s_readdatavalid_o), e[32] ? 32'd2 : 32'd1);
          chk("rdata", s_readdata_o, e[31:0]);
        end
      end
    end
  end

  task automatic drain();
    int cyc = 0;
    while ((req_q.size() != 0 || rd_q.size() != 0) && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("drain", 32'(req_q.size() + rd_q.size()), 32'd0);
  endtask

  task automatic do_write(input logic ch, input logic [31:0] addr, input int bc,
                          input logic [31:0] base, input bit toggle);
    int nb, beat, xfers, cyc;
    logic wr_ok;
    nb = (bc == 0) ? 1 : bc;
    req_q.push_back({1'b0, 3'(ch), 12'b0, 16'(nb)});
    req_q.push_back(32'(ADDR_W'(addr)));
    for (int b = 0; b < nb; b++) req_q.push_back(base + 32'(b));
    addr_a[ch]  = ADDR_W'(addr);
    bc_a[ch]    = BW'(bc);
    wdata_a[ch] = base;
    s_write_i[ch] = 1'b1;
    beat = 0; xfers = 0; cyc = 0;
    while (beat < nb && cyc < 200) begin
      @(negedge clk);
      wr_ok = !s_waitrequest_o[ch];
      if (xfers >= 2) chk("wreq_track", 32'(s_waitrequest_o[ch]), 32'(!req_ready_i));
      if (req_valid_o && req_ready_i) xfers++;
      @(posedge clk);
      #1;
      if (wr_ok) begin
        beat++;
        wdata_a[ch] = base + 32'(beat);
      end
      if (toggle) req_ready_i = ~req_ready_i;
      cyc++;
    end
    s_write_i[ch] = 1'b0;
    chk("wr_beats", 32'(beat), 32'(nb));
  endtask

  task automatic do_read(input logic ch, input logic [31:0] addr, input int bc,
                         input int nresp, input logic [31:0] base);
    int nb, cyc;
    logic acc;
    nb = (bc == 0) ? 1 : bc;
    req_q.push_back({1'b1, 3'(ch), 12'b0, 16'(nb)});
    req_q.push_back(32'(ADDR_W'(addr)));
    addr_a[ch] = ADDR_W'(addr);
    bc_a[ch]   = BW'(bc);
    s_read_i[ch] = 1'b1;
    acc = 1'b0; cyc = 0;
    while (!acc && cyc < 100) begin
      @(negedge clk);
      acc = !s_waitrequest_o[ch];
      @(posedge clk);
      #1;
      cyc++;
    end
    s_read_i[ch] = 1'b0;
    chk("rd_accept", 32'(acc), 32'd1);
    for (int i = 0; i < nresp; i++) begin
      resp_valid_i = 1'b1;
      resp_data_i  = base + 32'(i);
      rd_q.push_back({ch, resp_data_i});
      tick();
      resp_valid_i = 1'b0;
      chk("rdv_pulse", 32'(s_readdatavalid_o[ch]), 32'd1);
      tick();
      chk("rdv_gap", 32'(s_readdatavalid_o[ch]), 32'd0);
    end
    for (int i = nresp; i < nb; i++) rd_q.push_back({ch, 32'hDEAD_BEEF});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic got, wch;
    int cyc;
    rst = 1'b1; req_ready_i = 1'b1; resp_valid_i = 1'b0; resp_data_i = '0;
    s_write_i = '0; s_read_i = '0;
    for (int k = 0; k < 2; k++) begin
      addr_a[k] = '0; wdata_a[k] = '0; bc_a[k] = '0;
    end
    #3;
    chk("rst_waitreq", 32'(s_waitrequest_o), 32'd3);
    chk("rst_req_valid", 32'(req_valid_o), 32'd0);
    chk("rst_req_data", req_data_o, 32'd0);
    chk("rst_rdv", 32'(s_readdatavalid_o), 32'd0);
    chk("rst_rdata", s_readdata_o, 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    tick();

    // Write burst of 3 on ch0
    do_write(1'b0, 32'h100, 3, 32'h1111_0000, 1'b0);
    drain();
    chk("err_after_write", 32'(err_o), 32'd0);

    // Read burst of 2 on ch1
    do_read(1'b1, 32'h40, 2, 2, 32'hD000_0000);
    drain();
    chk("err_after_read", 32'(err_o), 32'd0);

    // Both channels reading continuously; ch1 uses burstcount 0
    addr_a[0] = ADDR_W'(32'h200); bc_a[0] = BW'(1);
    addr_a[1] = ADDR_W'(32'h300); bc_a[1] = BW'(0);
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) begin
        req_q.push_back(32'h8000_0001); req_q.push_back(32'h0000_0200);
      end else begin
        req_q.push_back(32'h9000_0001); req_q.push_back(32'h0000_0300);
      end
    end
    s_read_i = 2'b11;
    for (int i = 0; i < 4; i++) begin
      got = 1'b0; wch = 1'b0; cyc = 0;
      while (!got && cyc < 50) begin
        @(negedge clk);
        got = (s_waitrequest_o != 2'b11);
        wch = !s_waitrequest_o[1];
        @(posedge clk);
        #1;
        cyc++;
      end
      chk("rr_accept", 32'(got), 32'd1);
      chk("rr_grant", 32'(wch), 32'(i % 2));
      resp_valid_i = 1'b1;
      resp_data_i  = 32'hA000_0000 + 32'(i);
      rd_q.push_back({wch, resp_data_i});
      if (i == 3) s_read_i = 2'b00;
      tick();
      resp_valid_i = 1'b0;
    end
    drain();

    // 4-beat write with ready toggling every cycle
    do_write(1'b0, 32'h20, 4, 32'hB000_0000, 1'b1);
    req_ready_i = 1'b1;
    drain();

    // Read of 4 with one response, remainder times out
    do_read(1'b0, 32'h10, 4, 1, 32'hC0DE_0000);
    drain();
    chk("err_timeout", 32'(err_o), 32'd1);

    // Reset in the middle of a write data phase
    addr_a[0] = ADDR_W'(32'h55); bc_a[0] = BW'(4); wdata_a[0] = 32'h5000_0000;
    req_q.push_back(32'h0000_0004); req_q.push_back(32'h0000_0055);
    s_write_i[0] = 1'b1;
    tick(); tick(); tick();
    chk("pre_rst_valid", 32'(req_valid_o), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_waitreq", 32'(s_waitrequest_o), 32'd3);
    chk("mid_rst_req_valid", 32'(req_valid_o), 32'd0);
    chk("mid_rst_req_data", req_data_o, 32'd0);
    chk("mid_rst_rdata", s_readdata_o, 32'd0);
    chk("mid_rst_err", 32'(err_o), 32'd0);
    req_q.delete();
    s_write_i = '0;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_idle", 32'(req_valid_o), 32'd0);
    end
    do_write(1'b1, 32'h7F, 1, 32'h0000_1234, 1'b0);
    drain();
    chk("err_final", 32'(err_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
